// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two result FIFOs (ALU, LSU) feeding one
// registered broadcast bus with round-robin priority and rollback flush.
module cdb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ROB_ID_W   = 6,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                rollback_flag_in,
  input  logic                alu_valid_in,
  output logic                alu_ready_out,
  input  logic [ROB_ID_W-1:0] alu_rob_id_in,
  input  logic [DATA_W-1:0]   alu_result_in,
  input  logic [DATA_W-1:0]   alu_target_in,
  input  logic                alu_jump_in,
  input  logic                lsu_valid_in,
  output logic                lsu_ready_out,
  input  logic [ROB_ID_W-1:0] lsu_rob_id_in,
  input  logic [DATA_W-1:0]   lsu_result_in,
  output logic                cdb_valid_out,
  output logic                cdb_src_out,
  output logic [ROB_ID_W-1:0] cdb_rob_id_out,
  output logic [DATA_W-1:0]   cdb_result_out,
  output logic [DATA_W-1:0]   cdb_target_out,
  output logic                cdb_jump_out,
  output logic [CNT_W-1:0]    alu_count_out,
  output logic [CNT_W-1:0]    lsu_count_out
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [ROB_ID_W-1:0] r_alu_id  [FIFO_DEPTH];
  logic [DATA_W-1:0]   r_alu_res [FIFO_DEPTH];
  logic [DATA_W-1:0]   r_alu_tgt [FIFO_DEPTH];
  logic                r_alu_jmp [FIFO_DEPTH];
  logic [ROB_ID_W-1:0] r_lsu_id  [FIFO_DEPTH];
  logic [DATA_W-1:0]   r_lsu_res [FIFO_DEPTH];

  logic [PTR_W-1:0] r_alu_hd;
  logic [PTR_W-1:0] r_alu_tl;
  logic [CNT_W-1:0] r_alu_cnt;
  logic [PTR_W-1:0] r_lsu_hd;
  logic [PTR_W-1:0] r_lsu_tl;
  logic [CNT_W-1:0] r_lsu_cnt;

  // 1 = LSU granted last, so ALU wins the next tie
  logic r_last;

  logic                r_cdb_valid;
  logic                r_cdb_src;
  logic [ROB_ID_W-1:0] r_cdb_id;
  logic [DATA_W-1:0]   r_cdb_res;
  logic [DATA_W-1:0]   r_cdb_tgt;
  logic                r_cdb_jmp;

  logic w_en;
  logic w_alu_rdy;
  logic w_lsu_rdy;
  logic w_alu_push;
  logic w_lsu_push;
  logic w_alu_ne;
  logic w_lsu_ne;
  logic w_gnt_alu;
  logic w_gnt_lsu;

  assign w_en      = rdy_in & ~rollback_flag_in;
  assign w_alu_rdy = r_alu_cnt < DEPTH_C;
  assign w_lsu_rdy = r_lsu_cnt < DEPTH_C;

  // id 0 is handshaken but never stored
  assign w_alu_push = w_en & alu_valid_in & w_alu_rdy
                    & (alu_rob_id_in != '0);
  assign w_lsu_push = w_en & lsu_valid_in & w_lsu_rdy
                    & (lsu_rob_id_in != '0);

  assign w_alu_ne  = r_alu_cnt != '0;
  assign w_lsu_ne  = r_lsu_cnt != '0;
  assign w_gnt_alu = w_en & w_alu_ne & (~w_lsu_ne | r_last);
  assign w_gnt_lsu = w_en & w_lsu_ne & (~w_alu_ne | ~r_last);

  always_ff @(posedge clk_in) begin
    if (w_alu_push) begin
      r_alu_id[r_alu_tl]  <= alu_rob_id_in;
      r_alu_res[r_alu_tl] <= alu_result_in;
      r_alu_tgt[r_alu_tl] <= alu_target_in;
      r_alu_jmp[r_alu_tl] <= alu_jump_in;
    end
    if (w_lsu_push) begin
      r_lsu_id[r_lsu_tl]  <= lsu_rob_id_in;
      r_lsu_res[r_lsu_tl] <= lsu_result_in;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_alu_hd  <= '0;
      r_alu_tl  <= '0;
      r_alu_cnt <= '0;
      r_lsu_hd  <= '0;
      r_lsu_tl  <= '0;
      r_lsu_cnt <= '0;
      r_last    <= 1'b1;
    end else if (rdy_in) begin
      if (rollback_flag_in) begin
        r_alu_hd  <= '0;
        r_alu_tl  <= '0;
        r_alu_cnt <= '0;
        r_lsu_hd  <= '0;
        r_lsu_tl  <= '0;
        r_lsu_cnt <= '0;
        r_last    <= 1'b1;
      end else begin
        if (w_alu_push) r_alu_tl <= r_alu_tl + PTR_W'(1);
        if (w_gnt_alu)  r_alu_hd <= r_alu_hd + PTR_W'(1);
        if (w_lsu_push) r_lsu_tl <= r_lsu_tl + PTR_W'(1);
        if (w_gnt_lsu)  r_lsu_hd <= r_lsu_hd + PTR_W'(1);
        r_alu_cnt <= r_alu_cnt + CNT_W'(w_alu_push)
                   - CNT_W'(w_gnt_alu);
        r_lsu_cnt <= r_lsu_cnt + CNT_W'(w_lsu_push)
                   - CNT_W'(w_gnt_lsu);
        if (w_gnt_alu)      r_last <= 1'b0;
        else if (w_gnt_lsu) r_last <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cdb_valid <= 1'b0;
      r_cdb_src   <= 1'b0;
      r_cdb_id    <= '0;
      r_cdb_res   <= '0;
      r_cdb_tgt   <= '0;
      r_cdb_jmp   <= 1'b0;
    end else if (rdy_in) begin
      r_cdb_valid <= w_gnt_alu | w_gnt_lsu;
      if (w_gnt_alu) begin
        r_cdb_src <= 1'b0;
        r_cdb_id  <= r_alu_id[r_alu_hd];
        r_cdb_res <= r_alu_res[r_alu_hd];
        r_cdb_tgt <= r_alu_tgt[r_alu_hd];
        r_cdb_jmp <= r_alu_jmp[r_alu_hd];
      end else if (w_gnt_lsu) begin
        r_cdb_src <= 1'b1;
        r_cdb_id  <= r_lsu_id[r_lsu_hd];
        r_cdb_res <= r_lsu_res[r_lsu_hd];
        r_cdb_tgt <= '0;
        r_cdb_jmp <= 1'b0;
      end
    end
  end

  assign alu_ready_out  = w_alu_rdy;
  assign lsu_ready_out  = w_lsu_rdy;
  assign cdb_valid_out  = r_cdb_valid;
  assign cdb_src_out    = r_cdb_src;
  assign cdb_rob_id_out = r_cdb_id;
  assign cdb_result_out = r_cdb_res;
  assign cdb_target_out = r_cdb_tgt;
  assign cdb_jump_out   = r_cdb_jmp;
  assign alu_count_out  = r_alu_cnt;
  assign lsu_count_out  = r_lsu_cnt;

endmodule
